lsu_mem_ctrl: RTL

Load/store sequencer between the RISC-V core's memory stage and the byte-addressable data RAM. Accepts one RV32 load or store per handshake, decodes funct3 into byte masks, and splits misaligned halfword/word accesses into single-byte RAM beats. Assembles and sign- or zero-extends load data, then returns a one-cycle response. It is the only master driving the data RAM's address, write-data, mask and write-enable pins.

---
 rtl/lsu_mem_ctrl_if.sv | 40 ++++
 rtl/lsu_mem_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: bundles the load/store request/response channel and the
// data RAM pins of lsu_mem_ctrl.
//   req_*  : one RV32 load/store per valid/ready handshake
//   rsp_*  : one-cycle response pulse with extended load data and error flag
//   mem_*  : byte-addressed RAM address, write data, byte mask, write enable,
//            and combinational read data back from the RAM
// Modports are named from the request channel's point of view: master is the
// core/RAM environment, slave is the controller.
interface lsu_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_bmask;
  logic              mem_wren;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_wdata, mem_bmask, mem_wren
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_wdata, mem_bmask, mem_wren
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store sequencer between the core memory stage and the
// byte-addressable data RAM. Decodes funct3 into byte masks, splits misaligned
// half/word accesses into single-byte beats, assembles and extends load data
// and returns a one-cycle response.
// Ports:
//   i_clk     : clock, rising edge
//   i_reset_n : asynchronous active-low reset
//   bus       : lsu_mem_ctrl_if.slave (request, response and RAM pins)
module lsu_mem_ctrl #(
  parameter int unsigned ADDR_W = 11
) (
  input logic           i_clk,
  input logic           i_reset_n,
  lsu_mem_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [31:0]       asm_q, asm_d;
  logic              we_q, err_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              accept;
  logic              legal;
  logic [3:0]        size_mask;
  logic [31:0]       mask32;
  logic              split;
  logic [1:0]        last_beat;
  logic [31:0]       ext_data;

  assign accept = (state_q == StIdle) && bus.req_valid;

  always_comb begin
    legal = 1'b0;
    if (bus.req_we) begin
      legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
              (bus.req_funct3 == 3'b010);
    end else begin
      case (bus.req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end
  end

  // Size decode from the latched funct3; only legal codes reach ACCESS.
  always_comb begin
    case (f3_q[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  assign mask32 = {{8{size_mask[3]}}, {8{size_mask[2]}}, {8{size_mask[1]}}, {8{size_mask[0]}}};

  always_comb begin
    split     = 1'b0;
    last_beat = 2'd0;
    if (f3_q[1:0] == 2'b01 && addr_q[0]) begin
      split     = 1'b1;
      last_beat = 2'd1;
    end else if (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00) begin
      split     = 1'b1;
      last_beat = 2'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    asm_d   = asm_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          beat_d  = 2'd0;
          asm_d   = 32'd0;
          state_d = legal ? StAccess : StResp;
        end
      end
      StAccess: begin
        if (!we_q) begin
          if (split) asm_d[{beat_q, 3'b000} +: 8] = bus.mem_rdata[7:0];
          else       asm_d = bus.mem_rdata & mask32;
        end
        if (beat_q == last_beat) state_d = StResp;
        else                     beat_d  = beat_q + 2'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      beat_q  <= 2'd0;
      asm_q   <= 32'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      asm_q   <= asm_d;
      if (accept) begin
        we_q    <= bus.req_we;
        err_q   <= !legal;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
    end
  end

  // RAM pins are only non-zero while a beat is on the bus.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'd0;
    bus.mem_bmask = 4'd0;
    bus.mem_wren  = 1'b0;
    if (state_q == StAccess) begin
      bus.mem_addr = addr_q + ADDR_W'(beat_q);
      bus.mem_wren = we_q;
      if (split) begin
        bus.mem_bmask = 4'b0001;
        bus.mem_wdata = {24'd0, wdata_q[{beat_q, 3'b000} +: 8]};
      end else begin
        bus.mem_bmask = size_mask;
        bus.mem_wdata = wdata_q & mask32;
      end
    end
  end

  always_comb begin
    case (f3_q)
      3'b000:  ext_data = {{24{asm_q[7]}}, asm_q[7:0]};
      3'b001:  ext_data = {{16{asm_q[15]}}, asm_q[15:0]};
      3'b100:  ext_data = {24'd0, asm_q[7:0]};
      3'b101:  ext_data = {16'd0, asm_q[15:0]};
      default: ext_data = asm_q;
    endcase
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_err   = (state_q == StResp) && err_q;
  assign bus.rsp_rdata = ((state_q == StResp) && !err_q && !we_q) ? ext_data : 32'd0;

endmodule
